cvxif_core_adapter: RTL and testbench
=====================================

Name: cvxif_core_adapter

Overview:
- Core-side initiator of the CoreV-X-Interface: takes offload candidates from the core issue stage, drives the issue handshake, forwards commit/kill, and accepts coprocessor results.
- Tracks outstanding offloaded instructions in a small ID table and returns writeback data to the core's result stage.
- Sits between the issue/commit stages and any CV-X-IF coprocessor; it connects to the coprocessor through the packed cvxif_req_t/cvxif_resp_t structs.

Parameters:
- NbOutstanding, 4, max accepted-but-unfinished offloaded instructions (table depth, >=1).
- ResultBuffer, 1, 1 = registered one-entry result buffer; 0 = combinational pass-through.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- instr_valid_i  in  1  core offers an instruction.
- instr_ready_o  out  1  adapter can take an instruction.
- instr_i  in  32  instruction word.
- rs_i  in  X_NUM_RS*X_RFR_WIDTH  source operands.
- id_i  in  X_ID_WIDTH  core-assigned ID.
- issue_done_o  out  1  one-cycle pulse when the issue handshake completes.
- issue_accept_o  out  1  coprocessor accepted; qualified by issue_done_o (0 = illegal instruction).
- issue_wb_o  out  1  accepted instruction will write rd; qualified by issue_done_o.
- commit_valid_i  in  1  commit decision.
- commit_id_i  in  X_ID_WIDTH  ID being committed or killed.
- commit_kill_i  in  1  kill instead of commit.
- result_valid_o  out  1  writeback available.
- result_ready_i  in  1  core accepts the writeback.
- result_id_o  out  X_ID_WIDTH  ID of the result.
- result_data_o  out  X_RFW_WIDTH  result data.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  write enable.
- result_exc_o  out  1  exception flag.
- result_exccode_o  out  6  exception code.
- protocol_err_o  out  1  one-cycle pulse on an unknown, uncommitted or killed-ID result, or an unknown-ID commit.
- cvxif_req_o  out  cvxif_req_t  to coprocessor.
- cvxif_resp_i  in  cvxif_resp_t  from coprocessor.

Behaviour:
- Reset values:
  - x_issue_valid 0, x_commit_valid 0, x_result_ready 1.
  - Compressed and memory-interface request fields all 0.
  - result_valid_o 0, issue_done_o 0, protocol_err_o 0.
  - Table empty; instr_ready_o 1.
- Issue FSM states: IDLE, ISSUE.
  - IDLE: instr_ready_o = ~table_full & ~id_in_table(id_i).
  - IDLE, on instr_valid_i & instr_ready_o: latch instr, rs, id into the issue register; go to ISSUE next cycle.
  - ISSUE: x_issue_valid = 1 and x_issue_req is held stable until x_issue_ready; instr_ready_o = 0.
  - Handshake cycle (valid & ready): sample accept/writeback, pulse issue_done_o the next cycle, return to IDLE.
  - Issue latency: core handshake to x_issue_valid is 1 cycle; minimum instruction-to-instruction spacing is 2 cycles.
- Table allocation:
  - accept = 1: allocate an entry {id, writeback, committed = 0}.
  - accept = 0: no allocation; the core raises an illegal-instruction exception.
- Commit path: combinational pass-through (x_commit_valid = commit_valid_i, id and kill forwarded).
  - Matching entry, kill: entry freed.
  - Matching entry, commit: entry marked committed.
  - No matching entry: commit still forwarded, protocol_err_o pulses.
- Result path: x_result_ready = ~buf_valid | result_ready_i (ResultBuffer = 1).
  - Result on a committed matching entry: stored in the buffer, entry freed on that same handshake.
  - Result with unknown ID, or on an uncommitted or killed entry: consumed, dropped, protocol_err_o pulses.
  - result_we_o = x_result.we & entry.writeback.
  - Buffer holds stable while result_valid_o & ~result_ready_i.
- Simultaneous events:
  - Same-cycle free and allocate are permitted.
  - Full/ID checks use the registered table, with no bypass; a freed slot becomes visible next cycle.
  - Commit-kill and result for the same ID in one cycle: kill wins, result dropped, protocol_err_o pulses.
  - Commit in the same cycle as the issue handshake of that ID: treated as an unknown ID (the core must wait for issue_done_o).
- Wrap-around: IDs are opaque; uniqueness is enforced only by the id_in_table stall.
- Asynchronous reset mid-transaction: FSM to IDLE, table cleared, buffer invalidated; the coprocessor is reset on the same rst_ni.

Decomposition:
- Shared package cvxif_pkg holds X_ID_WIDTH, X_NUM_RS, X_RFR_WIDTH, X_RFW_WIDTH and the request/response structs.
- New typedef for this block: cvxif_outstanding_t {id, writeback, committed, valid}.
- One sub-module, cvxif_id_table: parameterised CAM with alloc, commit/kill and free-by-ID ports, plus full and lookup-hit outputs.

Test Plan:
- Reset, then core offers id=3 with instr custom-add, rs={5,7}; coprocessor accepts (writeback=1); commit id=3; coprocessor returns data=12 -> issue_done_o and issue_accept_o pulse once, result_valid_o=1 with id=3, data=12, rd=instr[11:7], we=1; table empty afterwards.
- Coprocessor answers accept=0 to id=1 -> issue_done_o=1, issue_accept_o=0; no table entry; instr_ready_o=1 the following cycle.
- Issue ids 0..3 all accepted with no result -> instr_ready_o=0 on the 5th offer; commit id=0 and return its result -> instr_ready_o=1 the cycle after the free.
- Issue id=2, commit_kill id=2, coprocessor still returns id=2 -> result dropped, protocol_err_o pulses, result_valid_o stays 0.
- Hold result_ready_i=0 for 3 cycles with a committed result buffered -> result outputs stable; x_result_ready=0 for a second pending result; both delivered in order once ready rises.
- Assert rst_ni low during ISSUE with x_issue_ready=0 -> x_issue_valid=0 immediately (asynchronous), table empty, instr_ready_o=1 after release.

Source files
------------

// File: rtl/cvxif_pkg.sv
// CV-X-IF shared widths, request/response structs and adapter-local types.
package cvxif_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_NUM_RS    = 2;
    localparam int unsigned X_RFR_WIDTH = 32;
    localparam int unsigned X_RFW_WIDTH = 32;
    localparam int unsigned X_MEM_WIDTH = 32;

    typedef struct packed {
        logic [15:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                             instr;
        logic [X_ID_WIDTH-1:0]                   id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
        logic [X_NUM_RS-1:0]                     rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [31:0]            addr;
        logic                   we;
        logic [X_MEM_WIDTH-1:0] wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
        logic [5:0]             exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        x_mem_resp_t       x_mem_resp;
        logic              x_mem_result_valid;
        x_mem_result_t     x_mem_result;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  writeback;
        logic                  committed;
        logic                  valid;
    } cvxif_outstanding_t;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } issue_state_e;

endpackage

// File: rtl/cvxif_id_table.sv
// Small CAM of offloaded-but-unfinished instructions, keyed by the core-assigned ID.
module cvxif_id_table
    import cvxif_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_valid_i,
    input  logic [X_ID_WIDTH-1:0] alloc_id_i,
    input  logic                  alloc_wb_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  commit_hit_o,
    input  logic                  free_valid_i,
    input  logic [X_ID_WIDTH-1:0] free_id_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  lookup_hit_o,
    input  logic [X_ID_WIDTH-1:0] res_id_i,
    output logic                  res_hit_o,
    output cvxif_outstanding_t    res_entry_o,
    output logic                  full_o
);

    cvxif_outstanding_t [Depth-1:0] entries_q, entries_d;
    logic [Depth-1:0]               alloc_mask;
    logic                           slot_found;

    // All lookups see the registered table only; same-cycle updates show up next cycle.
    always_comb begin
        lookup_hit_o = 1'b0;
        commit_hit_o = 1'b0;
        res_hit_o    = 1'b0;
        res_entry_o  = '0;
        full_o       = 1'b1;
        alloc_mask   = '0;
        slot_found   = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (entries_q[i].valid) begin
                if (entries_q[i].id == lookup_id_i) lookup_hit_o = 1'b1;
                if (entries_q[i].id == commit_id_i) commit_hit_o = 1'b1;
                if (entries_q[i].id == res_id_i) begin
                    res_hit_o   = 1'b1;
                    res_entry_o = entries_q[i];
                end
            end else begin
                full_o = 1'b0;
                if (!slot_found) begin
                    alloc_mask[i] = 1'b1;
                    slot_found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (entries_q[i].valid && commit_valid_i && entries_q[i].id == commit_id_i) begin
                if (commit_kill_i) entries_d[i].valid = 1'b0;
                else               entries_d[i].committed = 1'b1;
            end
            if (entries_q[i].valid && free_valid_i && entries_q[i].id == free_id_i) begin
                entries_d[i].valid = 1'b0;
            end
            // Allocation only targets a slot empty in the registered table, so it never
            // collides with a same-cycle free or commit.
            if (alloc_valid_i && alloc_mask[i]) begin
                entries_d[i] = '{id: alloc_id_i, writeback: alloc_wb_i,
                                 committed: 1'b0, valid: 1'b1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) entries_q <= '0;
        else         entries_q <= entries_d;
    end

endmodule

// File: rtl/cvxif_core_adapter.sv
// Core-side CV-X-IF initiator: issue handshake, commit forwarding, outstanding-ID tracking
// and result return to the core.
module cvxif_core_adapter
    import cvxif_pkg::*;
#(
    parameter int unsigned NbOutstanding = 4,
    parameter bit          ResultBuffer  = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            instr_valid_i,
    output logic                            instr_ready_o,
    input  logic [31:0]                     instr_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_i,
    input  logic [X_ID_WIDTH-1:0]           id_i,
    output logic                            issue_done_o,
    output logic                            issue_accept_o,
    output logic                            issue_wb_o,
    input  logic                            commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           commit_id_i,
    input  logic                            commit_kill_i,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [X_ID_WIDTH-1:0]           result_id_o,
    output logic [X_RFW_WIDTH-1:0]          result_data_o,
    output logic [4:0]                      result_rd_o,
    output logic                            result_we_o,
    output logic                            result_exc_o,
    output logic [5:0]                      result_exccode_o,
    output logic                            protocol_err_o,
    output cvxif_req_t                      cvxif_req_o,
    input  cvxif_resp_t                     cvxif_resp_i
);

    issue_state_e                         state_q, state_d;
    logic [31:0]                          instr_q;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_q;
    logic [X_ID_WIDTH-1:0]                id_q;
    logic                                 issue_load, issue_fire;
    logic                                 issue_done_q, issue_accept_q, issue_wb_q;
    logic                                 protocol_err_q, protocol_err_d;

    logic               tbl_full, tbl_lookup_hit, tbl_commit_hit, tbl_res_hit;
    cvxif_outstanding_t res_entry;
    logic               x_result_ready, res_fire, res_good, res_deliverable, kill_same;
    x_result_t          res_in, res_out;
    logic               res_out_valid;

    assign issue_fire = (state_q == StIssue) && cvxif_resp_i.x_issue_ready;

    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        issue_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready_o = ~tbl_full & ~tbl_lookup_hit;
                if (instr_valid_i && instr_ready_o) begin
                    issue_load = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (cvxif_resp_i.x_issue_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            instr_q        <= '0;
            rs_q           <= '0;
            id_q           <= '0;
            issue_done_q   <= 1'b0;
            issue_accept_q <= 1'b0;
            issue_wb_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_load) begin
                instr_q <= instr_i;
                rs_q    <= rs_i;
                id_q    <= id_i;
            end
            issue_done_q   <= issue_fire;
            issue_accept_q <= issue_fire & cvxif_resp_i.x_issue_resp.accept;
            issue_wb_q     <= issue_fire & cvxif_resp_i.x_issue_resp.accept
                              & cvxif_resp_i.x_issue_resp.writeback;
            protocol_err_q <= protocol_err_d;
        end
    end

    cvxif_id_table #(
        .Depth(NbOutstanding)
    ) u_id_table (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_valid_i (issue_fire & cvxif_resp_i.x_issue_resp.accept),
        .alloc_id_i    (id_q),
        .alloc_wb_i    (cvxif_resp_i.x_issue_resp.writeback),
        .commit_valid_i(commit_valid_i),
        .commit_id_i   (commit_id_i),
        .commit_kill_i (commit_kill_i),
        .commit_hit_o  (tbl_commit_hit),
        .free_valid_i  (res_good),
        .free_id_i     (cvxif_resp_i.x_result.id),
        .lookup_id_i   (id_i),
        .lookup_hit_o  (tbl_lookup_hit),
        .res_id_i      (cvxif_resp_i.x_result.id),
        .res_hit_o     (tbl_res_hit),
        .res_entry_o   (res_entry),
        .full_o        (tbl_full)
    );

    // A kill arriving alongside the result of the same ID wins over the result.
    assign kill_same       = commit_valid_i & commit_kill_i
                             & (commit_id_i == cvxif_resp_i.x_result.id);
    assign res_deliverable = tbl_res_hit & res_entry.committed & ~kill_same;
    assign res_fire        = cvxif_resp_i.x_result_valid & x_result_ready;
    assign res_good        = res_fire & res_deliverable;
    assign protocol_err_d  = (res_fire & ~res_deliverable) | (commit_valid_i & ~tbl_commit_hit);

    always_comb begin
        res_in    = cvxif_resp_i.x_result;
        res_in.we = cvxif_resp_i.x_result.we & res_entry.writeback;
    end

    if (ResultBuffer) begin : g_buf
        logic      buf_valid_q;
        x_result_t buf_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                buf_valid_q <= 1'b0;
                buf_q       <= '0;
            end else if (res_good) begin
                buf_valid_q <= 1'b1;
                buf_q       <= res_in;
            end else if (result_ready_i) begin
                buf_valid_q <= 1'b0;
            end
        end

        assign x_result_ready = ~buf_valid_q | result_ready_i;
        assign res_out_valid  = buf_valid_q;
        assign res_out        = buf_q;
    end else begin : g_pass
        // Undeliverable results are swallowed even while the core is stalled.
        assign x_result_ready = result_ready_i | ~res_deliverable;
        assign res_out_valid  = cvxif_resp_i.x_result_valid & res_deliverable;
        assign res_out        = res_in;
    end

    assign result_valid_o   = res_out_valid;
    assign result_id_o      = res_out.id;
    assign result_data_o    = res_out.data;
    assign result_rd_o      = res_out.rd;
    assign result_we_o      = res_out.we;
    assign result_exc_o     = res_out.exc;
    assign result_exccode_o = res_out.exccode;
    assign issue_done_o     = issue_done_q;
    assign issue_accept_o   = issue_accept_q;
    assign issue_wb_o       = issue_wb_q;
    assign protocol_err_o   = protocol_err_q;

    always_comb begin
        cvxif_req_o                          = '0;
        cvxif_req_o.x_issue_valid            = (state_q == StIssue);
        cvxif_req_o.x_issue_req.instr        = instr_q;
        cvxif_req_o.x_issue_req.id           = id_q;
        cvxif_req_o.x_issue_req.rs           = rs_q;
        cvxif_req_o.x_issue_req.rs_valid     = '1;
        cvxif_req_o.x_commit_valid           = commit_valid_i;
        cvxif_req_o.x_commit.id              = commit_id_i;
        cvxif_req_o.x_commit.commit_kill     = commit_kill_i;
        cvxif_req_o.x_result_ready           = x_result_ready;
    end

    // Compressed and memory interfaces are not supported by this core.
    logic unused_resp;
    assign unused_resp = ^{cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_compressed_resp,
                           cvxif_resp_i.x_issue_resp.dualwrite,
                           cvxif_resp_i.x_issue_resp.dualread,
                           cvxif_resp_i.x_issue_resp.loadstore,
                           cvxif_resp_i.x_issue_resp.exc,
                           cvxif_resp_i.x_mem_valid, cvxif_resp_i.x_mem_req};

endmodule

// File: tb/tb_cvxif_core_adapter.sv
// Self-checking bench for cvxif_core_adapter: directed vector table, hand-written corner
// sequences and a randomized run against an ID-set reference model.
module tb_cvxif_core_adapter;
    import cvxif_pkg::*;

    logic                            clk_i = 1'b0;
    logic                            rst_ni;
    logic                            instr_valid_i;
    logic                            instr_ready_o;
    logic [31:0]                     instr_i;
    logic [X_NUM_RS*X_RFR_WIDTH-1:0] rs_i;
    logic [X_ID_WIDTH-1:0]           id_i;
    logic                            issue_done_o, issue_accept_o, issue_wb_o;
    logic                            commit_valid_i, commit_kill_i;
    logic [X_ID_WIDTH-1:0]           commit_id_i;
    logic                            result_valid_o, result_ready_i;
    logic [X_ID_WIDTH-1:0]           result_id_o;
    logic [X_RFW_WIDTH-1:0]          result_data_o;
    logic [4:0]                      result_rd_o;
    logic                            result_we_o, result_exc_o;
    logic [5:0]                      result_exccode_o;
    logic                            protocol_err_o;
    cvxif_req_t                      req;
    cvxif_resp_t                     resp;

    cvxif_core_adapter #(
        .NbOutstanding(4),
        .ResultBuffer (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .instr_i         (instr_i),
        .rs_i            (rs_i),
        .id_i            (id_i),
        .issue_done_o    (issue_done_o),
        .issue_accept_o  (issue_accept_o),
        .issue_wb_o      (issue_wb_o),
        .commit_valid_i  (commit_valid_i),
        .commit_id_i     (commit_id_i),
        .commit_kill_i   (commit_kill_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_id_o     (result_id_o),
        .result_data_o   (result_data_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .result_exc_o    (result_exc_o),
        .result_exccode_o(result_exccode_o),
        .protocol_err_o  (protocol_err_o),
        .cvxif_req_o     (req),
        .cvxif_resp_i    (resp)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd);
        return {7'd0, 5'd11, 5'd10, 3'd0, rd, 7'b0001011};
    endfunction

    task automatic do_issue(input logic [3:0] id, input logic [4:0] rd, input logic acc,
                            input logic wb, input int stall, input string tag);
        instr_valid_i = 1'b1;
        instr_i       = mk_instr(rd);
        rs_i          = {32'd7, 32'd5};
        id_i          = id;
        #1;
        check($sformatf("%s instr_ready", tag), instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        instr_i       = '0;
        for (int s = 0; s < stall; s++) tick();
        check($sformatf("%s x_issue_valid", tag), req.x_issue_valid, 1'b1);
        check($sformatf("%s x_issue_id", tag), req.x_issue_req.id, id);
        check($sformatf("%s x_issue_instr", tag), req.x_issue_req.instr, mk_instr(rd));
        check($sformatf("%s x_issue_rs", tag), req.x_issue_req.rs, {32'd7, 32'd5});
        resp.x_issue_ready            = 1'b1;
        resp.x_issue_resp.accept      = acc;
        resp.x_issue_resp.writeback   = wb;
        tick();
        resp.x_issue_ready = 1'b0;
        resp.x_issue_resp  = '0;
        check($sformatf("%s issue_done", tag), issue_done_o, 1'b1);
        check($sformatf("%s issue_accept", tag), issue_accept_o, acc);
        check($sformatf("%s issue_wb", tag), issue_wb_o, acc & wb);
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic set_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                              input logic we);
        resp.x_result.id      = id;
        resp.x_result.data    = data;
        resp.x_result.rd      = rd;
        resp.x_result.we      = we;
        resp.x_result.exc     = 1'b0;
        resp.x_result.exccode = '0;
    endtask

    task automatic do_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                             input logic we);
        int n;
        set_result(id, data, rd, we);
        resp.x_result_valid = 1'b1;
        n = 0;
        #1;
        while (!req.x_result_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("result_wait_timeout", 1'b1, 1'b0);
        tick();
        resp.x_result_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  id;
        logic        acc;
        logic        wb;
        logic [1:0]  cmode;    // 0 none, 1 commit, 2 kill
        logic        send;
        logic [31:0] data;
        logic        we;
        logic        e_cerr;
        logic        e_rvalid;
        logic        e_rerr;
        logic        e_rwe;
        logic        cleanup;
    } vec_t;

    vec_t        vecs[8];
    vec_t        v;
    string       tag;
    logic [4:0]  rd;

    // Reference model: the set of outstanding IDs and their commit/writeback flags.
    bit          m_val[16];
    bit          m_com[16];
    bit          m_wb[16];
    int          m_cnt;
    int          op;
    logic [3:0]  rid;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic        racc, rwb, rwe, rkill, exp_b, deliver;

    initial begin
        rst_ni         = 1'b0;
        instr_valid_i  = 1'b0;
        instr_i        = '0;
        rs_i           = '0;
        id_i           = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b1;
        resp           = '0;

        vecs[0] = '{4'd3,  1, 1, 2'd1, 1, 32'd12,         1, 0, 1, 0, 1, 0};
        vecs[1] = '{4'd1,  0, 0, 2'd0, 0, 32'd0,          0, 0, 0, 0, 0, 0};
        vecs[2] = '{4'd2,  1, 1, 2'd2, 1, 32'd99,         1, 0, 0, 1, 0, 0};
        vecs[3] = '{4'd5,  1, 0, 2'd1, 1, 32'hdeadbeef,   1, 0, 1, 0, 0, 0};
        vecs[4] = '{4'd7,  1, 1, 2'd0, 1, 32'd5,          1, 0, 0, 1, 0, 1};
        vecs[5] = '{4'd9,  0, 0, 2'd1, 0, 32'd0,          0, 1, 0, 0, 0, 0};
        vecs[6] = '{4'd12, 0, 0, 2'd0, 1, 32'd3,          1, 0, 0, 1, 0, 0};
        vecs[7] = '{4'd6,  1, 1, 2'd1, 1, 32'h8000_0001,  0, 0, 1, 0, 0, 0};

        #12;
        check("rst x_issue_valid", req.x_issue_valid, 1'b0);
        check("rst x_commit_valid", req.x_commit_valid, 1'b0);
        check("rst x_result_ready", req.x_result_ready, 1'b1);
        check("rst mem fields", {req.x_mem_ready, req.x_mem_resp, req.x_mem_result_valid,
                                 req.x_mem_result, req.x_compressed_valid}, '0);
        check("rst result_valid", result_valid_o, 1'b0);
        check("rst issue_done", issue_done_o, 1'b0);
        check("rst protocol_err", protocol_err_o, 1'b0);
        check("rst instr_ready", instr_ready_o, 1'b1);
        #1 rst_ni = 1'b1;
        tick();

        foreach (vecs[k]) begin
            v   = vecs[k];
            tag = $sformatf("vec%0d", k);
            rd  = 5'(v.id) + 5'd8;
            do_issue(v.id, rd, v.acc, v.wb, k % 3, tag);
            if (!v.acc) check($sformatf("%s ready after reject", tag), instr_ready_o, 1'b1);
            if (v.cmode != 2'd0) begin
                do_commit(v.id, v.cmode == 2'd2);
                check($sformatf("%s commit err", tag), protocol_err_o, v.e_cerr);
            end
            if (v.send) begin
                do_result(v.id, v.data, rd, v.we);
                check($sformatf("%s result_valid", tag), result_valid_o, v.e_rvalid);
                check($sformatf("%s result err", tag), protocol_err_o, v.e_rerr);
                if (v.e_rvalid) begin
                    check($sformatf("%s result_id", tag), result_id_o, v.id);
                    check($sformatf("%s result_data", tag), result_data_o, v.data);
                    check($sformatf("%s result_rd", tag), result_rd_o, rd);
                    check($sformatf("%s result_we", tag), result_we_o, v.e_rwe);
                    check($sformatf("%s result_exc", tag), result_exc_o, 1'b0);
                end
            end
            if (v.cleanup) begin
                do_commit(v.id, 1'b1);
                check($sformatf("%s cleanup err", tag), protocol_err_o, 1'b0);
            end
            tick();
            id_i = v.id;
            #1;
            check($sformatf("%s id free after", tag), instr_ready_o, 1'b1);
            check($sformatf("%s done single pulse", tag), issue_done_o, 1'b0);
            check($sformatf("%s err single pulse", tag), protocol_err_o, 1'b0);
            check($sformatf("%s result drained", tag), result_valid_o, 1'b0);
        end

        // Fill the table, confirm the stall, then free one slot via commit + result.
        for (int i = 0; i < 4; i++) do_issue(4'(i), 5'd1, 1'b1, 1'b0, 0, "full");
        id_i          = 4'd8;
        instr_valid_i = 1'b1;
        #1;
        check("full stall ready", instr_ready_o, 1'b0);
        tick();
        instr_valid_i = 1'b0;
        check("full no issue", req.x_issue_valid, 1'b0);
        do_commit(4'd0, 1'b0);
        check("full commit err", protocol_err_o, 1'b0);
        set_result(4'd0, 32'd77, 5'd1, 1'b1);
        resp.x_result_valid = 1'b1;
        #1;
        check("full no bypass", instr_ready_o, 1'b0);
        tick();
        resp.x_result_valid = 1'b0;
        check("full result_valid", result_valid_o, 1'b1);
        check("full result_we gated", result_we_o, 1'b0);
        check("full freed visible", instr_ready_o, 1'b1);
        for (int i = 1; i < 4; i++) do_commit(4'(i), 1'b1);
        check("full cleanup err", protocol_err_o, 1'b0);
        tick();

        // Kill and result for the same ID in one cycle: kill wins.
        do_issue(4'd10, 5'd3, 1'b1, 1'b1, 0, "killwin");
        do_commit(4'd10, 1'b0);
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd10;
        commit_kill_i  = 1'b1;
        set_result(4'd10, 32'd55, 5'd3, 1'b1);
        resp.x_result_valid = 1'b1;
        tick();
        commit_valid_i      = 1'b0;
        commit_kill_i       = 1'b0;
        resp.x_result_valid = 1'b0;
        check("killwin result_valid", result_valid_o, 1'b0);
        check("killwin err", protocol_err_o, 1'b1);
        tick();
        id_i = 4'd10;
        #1;
        check("killwin entry freed", instr_ready_o, 1'b1);

        // Core back-pressure with a second result waiting behind the buffer.
        do_issue(4'd4, 5'd4, 1'b1, 1'b1, 0, "bp");
        do_commit(4'd4, 1'b0);
        do_issue(4'd6, 5'd6, 1'b1, 1'b1, 1, "bp");
        do_commit(4'd6, 1'b0);
        result_ready_i = 1'b0;
        do_result(4'd4, 32'h44, 5'd4, 1'b1);
        set_result(4'd6, 32'h66, 5'd6, 1'b1);
        resp.x_result_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp second blocked", req.x_result_ready, 1'b0);
            check("bp hold valid", result_valid_o, 1'b1);
            check("bp hold id/data", {result_id_o, result_data_o}, {4'd4, 32'h44});
            tick();
        end
        result_ready_i = 1'b1;
        #1;
        check("bp second ready", req.x_result_ready, 1'b1);
        tick();
        resp.x_result_valid = 1'b0;
        check("bp second valid", result_valid_o, 1'b1);
        check("bp second id/data", {result_id_o, result_data_o}, {4'd6, 32'h66});
        tick();
        check("bp drained", result_valid_o, 1'b0);

        // Asynchronous reset while the coprocessor is stalling the issue.
        do_issue(4'd3, 5'd2, 1'b1, 1'b1, 0, "rst");
        id_i          = 4'd5;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        check("rst mid issue valid", req.x_issue_valid, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        check("rst async x_issue_valid", req.x_issue_valid, 1'b0);
        check("rst async result_valid", result_valid_o, 1'b0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        id_i = 4'd3;
        #1;
        check("rst table cleared", instr_ready_o, 1'b1);

        // Randomized traffic against the ID-set model.
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 1'b0;
            m_com[i] = 1'b0;
            m_wb[i]  = 1'b0;
        end
        m_cnt = 0;
        for (int it = 0; it < 200; it++) begin
            op = int'($urandom_range(2));
            if (m_cnt > 0 && $urandom_range(1) == 1) begin
                do rid = 4'($urandom_range(15)); while (!m_val[rid]);
            end else begin
                rid = 4'($urandom_range(15));
            end
            rrd = 5'($urandom_range(31));
            case (op)
                0: begin
                    id_i  = rid;
                    #1;
                    exp_b = (m_cnt < 4) && !m_val[rid];
                    check("rnd instr_ready", instr_ready_o, exp_b);
                    if (exp_b) begin
                        racc = 1'($urandom_range(1));
                        rwb  = 1'($urandom_range(1));
                        do_issue(rid, rrd, racc, rwb, int'($urandom_range(2)), "rnd");
                        if (racc) begin
                            m_val[rid] = 1'b1;
                            m_com[rid] = 1'b0;
                            m_wb[rid]  = rwb;
                            m_cnt++;
                        end
                    end
                end
                1: begin
                    rkill = ($urandom_range(3) == 0);
                    exp_b = !m_val[rid];
                    do_commit(rid, rkill);
                    check("rnd commit err", protocol_err_o, exp_b);
                    if (m_val[rid]) begin
                        if (rkill) begin
                            m_val[rid] = 1'b0;
                            m_cnt--;
                        end else begin
                            m_com[rid] = 1'b1;
                        end
                    end
                end
                default: begin
                    rdata   = $urandom;
                    rwe     = 1'($urandom_range(1));
                    deliver = m_val[rid] && m_com[rid];
                    do_result(rid, rdata, rrd, rwe);
                    check("rnd result_valid", result_valid_o, deliver);
                    check("rnd result err", protocol_err_o, !deliver);
                    if (deliver) begin
                        check("rnd result id/data", {result_id_o, result_data_o}, {rid, rdata});
                        check("rnd result rd/we", {result_rd_o, result_we_o},
                              {rrd, rwe & m_wb[rid]});
                        m_val[rid] = 1'b0;
                        m_cnt--;
                    end
                end
            endcase
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
